// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: redirect/hazard controls in, ROM address/data, IF/ID register outputs.
// The slave side is the fetch stage; the master side is the surrounding core or a bench.
interface instruction_fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        irq;
  logic        exception;
  logic [30:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        irq_taken;
  logic [31:0] epc;

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, irq, exception, imem_instr,
    output imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, irq_taken, epc
  );

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, irq, exception, imem_instr,
    input  imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, irq_taken, epc
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, prioritised next-PC selection and the IF/ID register.
// pc[31] is the kernel flag; only pc[30:0] addresses the instruction ROM.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  instruction_fetch_stage_if.slave      bus
);

  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_BRANCH,
    SRC_JR,
    SRC_JUMP,
    SRC_HOLD,
    SRC_IRQ,
    SRC_SEQ
  } pc_src_e;

  logic [31:0] pc_q,            pc_d;
  logic [31:0] ifid_instr_q,    ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q,    ifid_valid_d;
  logic        irq_taken_q,     irq_taken_d;
  logic [31:0] epc_q,           epc_d;

  logic [31:0] pc_plus4;
  pc_src_e     pc_src;

  always_comb begin
    // Low 31 bits wrap on their own so the kernel flag never toggles.
    pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};

    if (bus.exception)                  pc_src = SRC_EXC;
    else if (bus.branch_taken)          pc_src = SRC_BRANCH;
    else if (bus.jr)                    pc_src = SRC_JR;
    else if (bus.jump)                  pc_src = SRC_JUMP;
    else if (bus.stall)                 pc_src = SRC_HOLD;
    else if (bus.irq && !pc_q[31])      pc_src = SRC_IRQ;
    else                                pc_src = SRC_SEQ;
  end

  always_comb begin
    pc_d            = pc_q;
    ifid_instr_d    = NOP_INSTR;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = 1'b0;
    irq_taken_d     = 1'b0;
    epc_d           = epc_q;

    unique case (pc_src)
      SRC_EXC: begin
        pc_d  = EXC_VEC;
        epc_d = ifid_pc_plus4_q - 32'd4;
      end
      SRC_BRANCH: pc_d = bus.branch_target;
      SRC_JR:     pc_d = bus.jr_target;
      SRC_JUMP:   pc_d = {ifid_pc_plus4_q[31:28], bus.jump_target, 2'b00};
      SRC_HOLD: begin
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
      end
      SRC_IRQ: begin
        pc_d        = IRQ_VEC;
        epc_d       = pc_q;
        irq_taken_d = 1'b1;
      end
      SRC_SEQ: begin
        pc_d            = pc_plus4;
        ifid_instr_d    = bus.imem_instr;
        ifid_pc_plus4_d = pc_plus4;
        ifid_valid_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      irq_taken_q     <= 1'b0;
      epc_q           <= '0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      irq_taken_q     <= irq_taken_d;
      epc_q           <= epc_d;
    end
  end

  assign bus.imem_addr     = pc_q[30:0];
  assign bus.pc            = pc_q;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_pc_plus4 = ifid_pc_plus4_q;
  assign bus.ifid_valid    = ifid_valid_q;
  assign bus.irq_taken     = irq_taken_q;
  assign bus.epc           = epc_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for the fetch stage; the ROM returns C0DE00xx where xx is the word index.
module tb_instruction_fetch_stage;

  logic clk;
  logic reset;
  int unsigned n_cmp;
  int unsigned n_err;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage #(
    .RESET_PC  (32'h8000_0000),
    .IRQ_VEC   (32'h8000_0004),
    .EXC_VEC   (32'h8000_0008),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_instr = {24'hC0DE00, bus.imem_addr[9:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.jump = 1'b0; bus.jump_target = '0; bus.jr = 1'b0; bus.jr_target = '0;
    bus.irq = 1'b0; bus.exception = 1'b0;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check({tag, ".instr"}, bus.ifid_instr, instr);
    check({tag, ".pc4"},   bus.ifid_pc_plus4, pc4);
    check({tag, ".valid"}, {31'd0, bus.ifid_valid}, {31'd0, valid});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    reset = 1'b1;

    // T1: reset, then sequential fetch from ROM word 0
    step(); step();
    check("t1.rst.pc", bus.pc, 32'h8000_0000);
    check("t1.rst.addr", {1'b0, bus.imem_addr}, 32'h0000_0000);
    check_ifid("t1.rst", 32'h0, 32'h0, 1'b0);
    check("t1.rst.epc", bus.epc, 32'h0);
    check("t1.rst.irqt", {31'd0, bus.irq_taken}, 32'h0);
    reset = 1'b0;
    step();
    check("t1.s1.pc", bus.pc, 32'h8000_0004);
    check("t1.s1.addr", {1'b0, bus.imem_addr}, 32'h0000_0004);
    check_ifid("t1.s1", 32'hC0DE_0000, 32'h8000_0004, 1'b1);
    step();
    check("t1.s2.pc", bus.pc, 32'h8000_0008);
    check("t1.s2.addr", {1'b0, bus.imem_addr}, 32'h0000_0008);
    check_ifid("t1.s2", 32'hC0DE_0001, 32'h8000_0008, 1'b1);
    step(); step(); step();
    check("t2.pre.pc", bus.pc, 32'h8000_0014);
    check_ifid("t2.pre", 32'hC0DE_0004, 32'h8000_0014, 1'b1);

    // T2: jump uses upper nibble of ifid_pc_plus4
    bus.jump = 1'b1; bus.jump_target = 26'h000_0006;
    step();
    idle_inputs();
    check("t2.pc", bus.pc, 32'h8000_0018);
    check_ifid("t2", 32'h0, 32'h8000_0014, 1'b0);

    // T3: branch to user space, stall three cycles, release
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_004C;
    step();
    idle_inputs();
    check("t3.br.pc", bus.pc, 32'h0000_004C);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3.stall.pc", bus.pc, 32'h0000_004C);
      check_ifid("t3.stall", 32'h0, 32'h8000_0014, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    check("t3.rel.pc", bus.pc, 32'h0000_0050);
    check_ifid("t3.rel", 32'hC0DE_0013, 32'h0000_0050, 1'b1);

    // T4: irq accepted in user mode, then ignored in kernel mode
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0040;
    step();
    idle_inputs();
    bus.irq = 1'b1;
    step();
    check("t4.irq.pc", bus.pc, 32'h8000_0004);
    check("t4.irq.epc", bus.epc, 32'h0000_0040);
    check("t4.irq.taken", {31'd0, bus.irq_taken}, 32'h1);
    check("t4.irq.valid", {31'd0, bus.ifid_valid}, 32'h0);
    step();
    check("t4.k.pc", bus.pc, 32'h8000_0008);
    check("t4.k.taken", {31'd0, bus.irq_taken}, 32'h0);
    bus.irq = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h8000_0040;
    step();
    idle_inputs();
    bus.irq = 1'b1;
    step();
    check("t4.k2.pc", bus.pc, 32'h8000_0044);
    check("t4.k2.taken", {31'd0, bus.irq_taken}, 32'h0);
    check("t4.k2.epc", bus.epc, 32'h0000_0040);
    check_ifid("t4.k2", 32'hC0DE_0010, 32'h8000_0044, 1'b1);
    bus.irq = 1'b0;

    // T5: exception beats branch and stall; jr beats irq
    bus.exception = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0123;
    bus.stall = 1'b1;
    step();
    idle_inputs();
    check("t5.exc.pc", bus.pc, 32'h8000_0008);
    check("t5.exc.epc", bus.epc, 32'h8000_0040);
    check_ifid("t5.exc", 32'h0, 32'h8000_0044, 1'b0);
    bus.jr = 1'b1; bus.jr_target = 32'h0000_0100;
    step();
    check("t5.jr1.pc", bus.pc, 32'h0000_0100);
    bus.jr_target = 32'h0000_0200; bus.irq = 1'b1;
    step();
    check("t5.jr2.pc", bus.pc, 32'h0000_0200);
    check("t5.jr2.taken", {31'd0, bus.irq_taken}, 32'h0);
    bus.jr = 1'b0;
    step();
    check("t5.irq.pc", bus.pc, 32'h8000_0004);
    check("t5.irq.epc", bus.epc, 32'h0000_0200);
    check("t5.irq.taken", {31'd0, bus.irq_taken}, 32'h1);
    bus.irq = 1'b0;

    // T6: reset overrides branch and stall
    reset = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0300; bus.stall = 1'b1;
    step();
    check("t6.pc", bus.pc, 32'h8000_0000);
    check_ifid("t6", 32'h0, 32'h0, 1'b0);
    check("t6.epc", bus.epc, 32'h0);
    check("t6.taken", {31'd0, bus.irq_taken}, 32'h0);

    // Wrap of the low 31 bits keeps the kernel flag
    reset = 1'b0; bus.stall = 1'b0; bus.branch_target = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    check("wrap.br.pc", bus.pc, 32'hFFFF_FFFC);
    step();
    check("wrap.pc", bus.pc, 32'h8000_0000);
    check_ifid("wrap", 32'hC0DE_00FF, 32'h8000_0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
